// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle ARM-subset sequencer with NZCV flags; define MC_MEMREADY_EN for MemReady wait states
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       NoWrite,
  input  logic       PCS,
`ifdef MC_MEMREADY_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [3:0] Flags,
  output logic [3:0] State
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
                         MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9;
  logic [3:0] state_q, state_d, flags_q, flags_d;
  logic       cond_ex, ready, exec, n, z, c, v;
  logic       unused_funct;
  assign unused_funct = ^Funct[4:1];
`ifdef MC_MEMREADY_EN
  assign ready = MemReady;
`else
  assign ready = 1'b1;
`endif
  assign {n, z, c, v} = flags_q;
  assign Flags = flags_q;
  assign State = state_q;
  assign exec = (state_q == EXECUTER) || (state_q == EXECUTEI);
  always_comb begin
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c & !z;
      4'b1001: cond_ex = !c | z;
      4'b1010: cond_ex = n == v;
      4'b1011: cond_ex = n != v;
      4'b1100: cond_ex = !z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end
  always_comb begin
    flags_d = {exec && FlagW[1] ? ALUFlags[3:2] : flags_q[3:2],
               exec && FlagW[0] ? ALUFlags[1:0] : flags_q[1:0]};
  end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:              state_d = ready ? DECODE : FETCH;
      DECODE:             state_d = !cond_ex ? FETCH :
                                    Op == 2'b01 ? MEMADR :
                                    Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                    Op == 2'b10 ? BRANCH : FETCH;
      MEMADR:             state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:            state_d = ready ? MEMWB : MEMREAD;
      MEMWRITE:           state_d = ready ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI: state_d = NoWrite ? FETCH : ALUWB;
      default:            state_d = FETCH;
    endcase
  end
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = ready;
        PCWrite   = ready;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = !PCS;
        PCWrite   = PCS;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegWrite = !PCS;
        PCWrite  = PCS;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized instruction stream checked against a per-instruction sequence model
module tb_mc_ctrl_fsm;
  logic       clk, reset;
  logic [1:0] Op, FlagW, ResultSrc, ALUSrcB;
  logic [5:0] Funct;
  logic [3:0] Cond, ALUFlags, Flags, State;
  logic       NoWrite, PCS, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUOp;
  logic [11:0] outs;
  logic [3:0] m_flags;
  int n_vec, n_err;
`ifdef MC_MEMREADY_EN
  logic mem_ready;
`endif

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .NoWrite(NoWrite), .PCS(PCS),
`ifdef MC_MEMREADY_EN
    .MemReady(mem_ready),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .Flags(Flags), .State(State)
  );

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp} per state
  function automatic logic [11:0] exp_out(input int s, input logic pcs);
    case (s)
      0: return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0};
      1: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b0};
      2: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
      3: return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
      4: return {pcs,  1'b0, 1'b0, 1'b0, !pcs, 2'b01, 1'b0, 2'b00, 1'b0};
      5: return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
      6: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
      7: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1};
      8: return {pcs,  1'b0, 1'b0, 1'b0, !pcs, 2'b00, 1'b0, 2'b00, 1'b0};
      9: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 1'b0};
      default: return 12'h000;
    endcase
  endfunction

  // ARM condition: even codes test a predicate, odd codes its inverse, 1111 inverts "always"
  function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
    logic nn, zz, cc, vv, base;
    {nn, zz, cc, vv} = f;
    case (cond[3:1])
      3'd0: base = zz;
      3'd1: base = cc;
      3'd2: base = nn;
      3'd3: base = vv;
      3'd4: base = cc && !zz;
      3'd5: base = nn == vv;
      3'd6: base = (nn == vv) && !zz;
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] cond, input logic [3:0] af, input logic [1:0] fw,
                           input logic nw, input logic pcs);
    int seq[$];
    logic ce;
    Op = op; Funct = funct; Cond = cond; ALUFlags = af; FlagW = fw; NoWrite = nw; PCS = pcs;
    ce = cond_model(cond, m_flags);
    seq = {0, 1};
    if (ce) begin
      if (op == 2'b01) begin
        seq.push_back(2);
        if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end else if (op == 2'b00) begin
        seq.push_back(funct[5] ? 7 : 6);
        if (!nw) seq.push_back(8);
        if (fw[1]) m_flags[3:2] = af[3:2];
        if (fw[0]) m_flags[1:0] = af[1:0];
      end else if (op == 2'b10) seq.push_back(9);
    end
    foreach (seq[i]) begin
      n_vec++;
      if (State !== 4'(seq[i]) || outs !== exp_out(seq[i], pcs)) begin
        n_err++;
        $display("FAIL %s step %0d: got state=%0d outs=%03h, expected state=%0d outs=%03h",
                 name, i, State, outs, seq[i], exp_out(seq[i], pcs));
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (State !== 4'd0 || Flags !== m_flags) begin
      n_err++;
      $display("FAIL %s end: got state=%0d flags=%b, expected state=0 flags=%b", name, State, Flags, m_flags);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_flags = 4'b0000;
    n_vec++;
    if (State !== 4'd0 || Flags !== 4'b0000 || outs !== exp_out(0, 1'b0)) begin
      n_err++;
      $display("FAIL reset: got state=%0d flags=%b outs=%03h, expected state=0 flags=0000 outs=%03h",
               State, Flags, outs, exp_out(0, 1'b0));
    end
  endtask

  task automatic test_directed();
    run_instr("adds",   2'b00, 6'b101001, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0);
    run_instr("cmp",    2'b00, 6'b010101, 4'b1110, 4'b0100, 2'b11, 1'b1, 1'b0);
    run_instr("beq",    2'b10, 6'b000000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
    run_instr("bne",    2'b10, 6'b000000, 4'b0001, 4'b1111, 2'b00, 1'b0, 1'b0);
    run_instr("ldr_pc", 2'b01, 6'b011001, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1);
    run_instr("str",    2'b01, 6'b011000, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0);
    run_instr("nv",     2'b00, 6'b101001, 4'b1111, 4'b1111, 2'b11, 1'b0, 1'b0);
    run_instr("op11",   2'b11, 6'b000000, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++)
      run_instr("rand", 2'($urandom_range(0, 3)), 6'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom), 4'($urandom),
                2'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_abort();
    run_instr("seed_flags", 2'b00, 6'b000000, 4'b1110, 4'b1011, 2'b11, 1'b1, 1'b0);
    Op = 2'b01; Funct = 6'b000000; Cond = 4'b1110; PCS = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_flags = 4'b0000;
    n_vec++;
    if (State !== 4'd0 || Flags !== 4'b0000 || outs !== exp_out(0, 1'b0)) begin
      n_err++;
      $display("FAIL reset_abort: got state=%0d flags=%b outs=%03h, expected state=0 flags=0000 outs=%03h",
               State, Flags, outs, exp_out(0, 1'b0));
    end
  endtask

`ifdef MC_MEMREADY_EN
  task automatic test_memready();
    int pcw;
    Op = 2'b01; Funct = 6'b000000; Cond = 4'b1110; PCS = 1'b0; NoWrite = 1'b0; FlagW = 2'b00;
    pcw = 0;
    mem_ready = 1'b0;
    repeat (2) begin
      pcw += int'(PCWrite);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    pcw += int'(PCWrite);
    @(posedge clk); #1;
    pcw += int'(PCWrite);
    n_vec++;
    if (pcw !== 1 || State !== 4'd1) begin
      n_err++;
      $display("FAIL fetch_wait: got pcwrite_pulses=%0d state=%0d, expected 1 and 1", pcw, State);
    end
    repeat (2) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      n_vec++;
      if (State !== 4'd5 || MemWrite !== 1'b1) begin
        n_err++;
        $display("FAIL memwrite_wait %0d: got state=%0d memwrite=%b, expected 5 and 1", i, State, MemWrite);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (State !== 4'd0) begin
      n_err++;
      $display("FAIL memwrite_done: got state=%0d, expected 0", State);
    end
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0; m_flags = 4'b0000;
    reset = 1'b1; Op = 2'b00; Funct = 6'b0; Cond = 4'b1110; ALUFlags = 4'b0;
    FlagW = 2'b00; NoWrite = 1'b0; PCS = 1'b0;
`ifdef MC_MEMREADY_EN
    mem_ready = 1'b1;
`endif
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
`ifdef MC_MEMREADY_EN
    test_memready();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle sequencing controller for the ARM-subset multicycle processor. It sits directly downstream of the combinational instruction decoder. It consumes the decoded instruction class, flag-write and PC-write hints, and the instruction condition field. It owns the NZCV flag register and the per-instruction state machine, and drives every datapath enable and mux select cycle by cycle.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch
- Funct  in  6  Funct[5] is the I (immediate) bit; Funct[0] is the L bit for memory instructions
- Cond  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- FlagW  in  2  [1] updates N,Z; [0] updates C,V
- NoWrite  in  1  data-processing instruction with no register result (CMP)
- PCS  in  1  instruction writes the PC
- MemReady  in  1  memory access complete (present only with MC_MEMREADY_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALU result register
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU direct
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 register, 01 extended immediate, 10 constant 4
- ALUOp  out  1  1 = decoder selects the ALU operation; 0 = ADD
- Flags  out  4  registered {N,Z,C,V}
- State  out  4  current state encoding (debug)

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Encodings 10–15 are illegal and go to FETCH on the next edge.
- The condition check CondEx is combinational from Cond and Flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z.
  - GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - 1110 always true; 1111 always false.
- Transitions:
  - FETCH → DECODE.
  - DECODE: → FETCH if !CondEx; else Op=01 → MEMADR; Op=00 with Funct[5]=1 → EXECUTEI; Op=00 with Funct[5]=0 → EXECUTER; Op=10 → BRANCH; Op=11 → FETCH.
  - MEMADR: → MEMREAD if Funct[0]=1, else → MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTER and EXECUTEI: → FETCH if NoWrite=1, else → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH → FETCH.
- Moore outputs; every output not listed for a state is 0:
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01; RegWrite=!PCS; PCWrite=PCS.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00; RegWrite=!PCS; PCWrite=PCS.
  - BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=1.
- Flag update:
  - Occurs at the end of EXECUTER or EXECUTEI only. CondEx is always true there, because failing instructions never reach these states.
  - N,Z ← ALUFlags[3:2] when FlagW[1]=1.
  - C,V ← ALUFlags[1:0] when FlagW[0]=1.
  - Flags are never written in any other state.

## Timing
- Reset (synchronous): State=FETCH and Flags=0000. Outputs therefore equal the FETCH values in the first cycle after reset.
- Reset asserted mid-instruction aborts the instruction at the next edge. No write strobe is issued in the cycle after that edge, other than the FETCH outputs.
- Cycles per instruction without wait states:
  - data-processing 4 (CMP 3)
  - LDR 5
  - STR 4
  - B 3
  - condition-failed 2
- Inputs are sampled only in the states that use them. Op, Funct, Cond, FlagW, NoWrite and PCS must be stable from DECODE through the instruction's last state; the instruction register guarantees this.
- A flag write at the end of EXECUTE is visible to CondEx from the next instruction's DECODE onward.

## Configuration
- MC_MEMREADY_EN defined:
  - The MemReady port exists.
  - FETCH, MEMREAD and MEMWRITE hold their state and outputs until a cycle with MemReady=1, then transition normally.
  - In FETCH, IRWrite and PCWrite are gated with MemReady, so the PC advances exactly once per fetch.
  - MemWrite stays asserted for every wait cycle.
- MC_MEMREADY_EN undefined: the port is absent, memory is single-cycle, and behaviour is as if MemReady=1.

## Test plan
- Reset held 2 cycles, then released → State=0, Flags=0000, IRWrite=PCWrite=1 in the first cycle.
- ADD with S bit (Op=00, Funct=101001, Cond=1110, FlagW=11), ALUFlags=0110 → states 0,1,7,8,0; RegWrite=1 in ALUWB; Flags=0110 after EXECUTEI.
- CMP (NoWrite=1) then BEQ with ALUFlags Z=1 → CMP takes states 0,1,6,0; branch takes states 0,1,9 with PCWrite=1 in BRANCH.
- BNE when Z=1 → states 0,1,0; no PCWrite in DECODE; Flags unchanged.
- LDR PC (Op=01, Funct[0]=1, PCS=1) → states 0,1,2,3,4; in MEMWB PCWrite=1, RegWrite=0, ResultSrc=01.
- With MC_MEMREADY_EN: STR with MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 cycles, then FETCH; FETCH with MemReady low for 2 cycles → PCWrite pulses exactly once.
